adc_sample_feeder: RTL and testbench

Upstream stage of the correlator array. Accepts raw 16-bit ADC samples, applies a programmable DC-offset correction with saturation, and buffers them in a small FIFO. It then broadcasts them on the shared `ADC`/`PushADC` bus that every correlator channel consumes, at a programmable pacing interval. Control and status registers sit on the same memory-mapped bus as the correlator channels.

---
 rtl/adc_sample_feeder.sv | 91 +++++++++
 tb/tb_adc_sample_feeder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_feeder.sv
// adc_sample_feeder: offset-corrected ADC capture into a FIFO, paced broadcast on the ADC/PushADC bus
module adc_sample_feeder #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] Wdata,
  input  logic        write,
  input  logic        read,
  output logic [31:0] Rdata,
  input  logic [15:0] adc_in,
  input  logic        adc_valid,
  output logic [15:0] ADC,
  output logic        PushADC,
  output logic        Overflow
);
  localparam logic [31:0] A_CTRL   = 32'hFE00_0200;
  localparam logic [31:0] A_PACE   = 32'hFE00_0204;
  localparam logic [31:0] A_OFFSET = 32'hFE00_0208;
  localparam logic [31:0] A_STATUS = 32'hFE00_020C;
  localparam logic [31:0] A_DROPS  = 32'hFE00_0210;
  logic          enable, overflow;
  logic [15:0]   pace_n, offset, pace_cnt, sample, reload;
  logic [31:0]   drops, rd_val;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic [16:0]   diff;
  logic          wr_ctrl, wr_pace, wr_offset, wr_status, wr_drops;
  logic          flush, empty, full, cap, pop, wr_en, drop, unused_ok;
  assign wr_ctrl   = write && addr == A_CTRL;
  assign wr_pace   = write && addr == A_PACE;
  assign wr_offset = write && addr == A_OFFSET;
  assign wr_status = write && addr == A_STATUS;
  assign wr_drops  = write && addr == A_DROPS;
  assign flush     = wr_ctrl && Wdata[1];
  assign empty     = level == '0;
  assign full      = level == (AW+1)'(DEPTH);
  assign cap       = adc_valid && enable && !flush;
  assign pop       = enable && pace_cnt == 16'd0 && !empty && !flush;
  assign wr_en     = cap && (!full || pop);
  assign drop      = cap && full && !pop;
  assign diff      = {adc_in[15], adc_in} - {offset[15], offset};
  assign sample    = (diff[16] ^ diff[15]) ? (diff[16] ? 16'h8000 : 16'h7FFF) : diff[15:0];
  assign reload    = (pace_n == 16'd0) ? 16'd0 : pace_n - 16'd1;
  assign rd_val    = (addr == A_CTRL)   ? {31'd0, enable} :
                     (addr == A_PACE)   ? {16'd0, pace_n} :
                     (addr == A_OFFSET) ? {16'd0, offset} :
                     (addr == A_STATUS) ? {14'd0, empty, overflow, {(15-AW){1'b0}}, level} :
                     (addr == A_DROPS)  ? drops : '0;
  assign Rdata     = (read && rst) ? rd_val : '0;
  assign Overflow  = overflow;
  assign unused_ok = ^Wdata[31:16];
  // control and status registers; a clearing write beats a same-cycle drop
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      enable   <= 1'b0;
      pace_n   <= 16'd1;
      offset   <= '0;
      overflow <= 1'b0;
      drops    <= '0;
    end else begin
      if (wr_ctrl) enable <= Wdata[0];
      if (wr_pace) pace_n <= Wdata[15:0];
      if (wr_offset) offset <= Wdata[15:0];
      overflow <= wr_status ? 1'b0 : overflow | drop;
      drops    <= wr_drops ? '0 : drops + {31'd0, drop && drops != '1};
    end
  // sample storage; a pop reads the old head so full-with-pop can overwrite safely
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= sample;
  // FIFO pointers, pacing counter and broadcast register
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      pace_cnt <= '0;
      ADC      <= '0;
      PushADC  <= 1'b0;
    end else begin
      wr_ptr   <= flush ? '0 : wr_ptr + AW'(wr_en);
      rd_ptr   <= flush ? '0 : rd_ptr + AW'(pop);
      level    <= flush ? '0 : level + (AW+1)'(wr_en) - (AW+1)'(pop);
      pace_cnt <= flush ? '0 : pop ? reload : (enable && pace_cnt != 16'd0) ? pace_cnt - 16'd1 : pace_cnt;
      PushADC  <= pop;
      if (pop) ADC <= mem[rd_ptr];
    end
endmodule

// File: tb/tb_adc_sample_feeder.sv
// tb_adc_sample_feeder: directed and random checks of adc_sample_feeder against a queue-based model
module tb_adc_sample_feeder;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam logic [31:0] A_CTRL   = 32'hFE00_0200;
  localparam logic [31:0] A_PACE   = 32'hFE00_0204;
  localparam logic [31:0] A_OFFSET = 32'hFE00_0208;
  localparam logic [31:0] A_STATUS = 32'hFE00_020C;
  localparam logic [31:0] A_DROPS  = 32'hFE00_0210;
  logic        clk = 0, rst = 0;
  logic [31:0] addr = 0, Wdata = 0;
  logic        write = 0, read = 0;
  logic [31:0] Rdata;
  logic [15:0] adc_in = 0;
  logic        adc_valid = 0;
  logic [15:0] ADC;
  logic        PushADC, Overflow;
  int total = 0, bad = 0, pushes = 0, snap = 0;
  logic [15:0] q[$];
  bit          m_en, m_ovf, m_push;
  int          m_n, m_cnt;
  logic [15:0] m_off, m_adc;
  logic [31:0] m_drops;

  adc_sample_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .addr(addr), .Wdata(Wdata), .write(write), .read(read),
    .Rdata(Rdata), .adc_in(adc_in), .adc_valid(adc_valid), .ADC(ADC),
    .PushADC(PushADC), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat(logic [15:0] a, logic [15:0] o);
    int d;
    d = int'($signed(a)) - int'($signed(o));
    if (d > 32767) d = 32767;
    else if (d < -32768) d = -32768;
    return d[15:0];
  endfunction

  task automatic mreset();
    q.delete();
    m_en = 0; m_ovf = 0; m_push = 0; m_n = 1; m_cnt = 0;
    m_off = 0; m_adc = 0; m_drops = 0;
  endtask

  // what one clock edge does, given the inputs currently driven
  task automatic model_edge();
    bit fl, pp, cp;
    fl = write && addr == A_CTRL && Wdata[1];
    pp = m_en && m_cnt == 0 && q.size() > 0 && !fl;
    cp = adc_valid && m_en && !fl;
    m_push = pp;
    if (fl) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (pp) begin
        m_adc = q.pop_front();
        m_cnt = (m_n == 0) ? 0 : m_n - 1;
      end else if (m_en && m_cnt > 0) m_cnt--;
      if (cp) begin
        if (q.size() < DEPTH) q.push_back(sat(adc_in, m_off));
        else begin
          m_ovf = 1;
          if (m_drops != 32'hFFFF_FFFF) m_drops++;
        end
      end
    end
    if (write)
      case (addr)
        A_CTRL:   m_en = Wdata[0];
        A_PACE:   m_n = int'(Wdata[15:0]);
        A_OFFSET: m_off = Wdata[15:0];
        A_STATUS: m_ovf = 0;
        A_DROPS:  m_drops = 0;
        default: ;
      endcase
  endtask

  function automatic logic [31:0] exp_rd(logic [31:0] a);
    case (a)
      A_CTRL:   return {31'd0, m_en};
      A_PACE:   return 32'(m_n);
      A_OFFSET: return {16'd0, m_off};
      A_STATUS: return 32'(q.size()) | (m_ovf ? 32'h1_0000 : 32'h0) | (q.size() == 0 ? 32'h2_0000 : 32'h0);
      A_DROPS:  return m_drops;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    if (PushADC === 1'b1) pushes++;
    chk("push", PushADC, m_push);
    chk("adc", ADC, m_adc);
    chk("overflow", Overflow, m_ovf);
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    addr = a; Wdata = d; write = 1;
    tick();
    write = 0;
  endtask

  task automatic rd(string tag, logic [31:0] a);
    addr = a; read = 1;
    #1;
    chk(tag, Rdata, exp_rd(a));
    read = 0;
  endtask

  task automatic smp(logic [15:0] v);
    adc_in = v; adc_valid = 1;
    tick();
    adc_valid = 0;
  endtask

  initial begin
    mreset();
    #12;
    chk("rst_push", PushADC, 0);
    chk("rst_adc", ADC, 0);
    chk("rst_ovf", Overflow, 0);
    addr = A_PACE; read = 1; #1;
    chk("rst_rdata", Rdata, 0);
    read = 0; rst = 1;
    @(posedge clk); #1;
    rd("pace_rst", A_PACE);
    rd("ctrl_rst", A_CTRL);
    rd("status_rst", A_STATUS);
    rd("drops_rst", A_DROPS);
    tick();
    rd("offset_rst", A_OFFSET);
    rd("unmapped", 32'hFE00_0214);
    addr = A_PACE; #1;
    chk("rdata_noread", Rdata, 0);
    // three back-to-back samples at pace 1
    wr(A_CTRL, 1);
    snap = pushes;
    smp(16'h0001); smp(16'h7FFF); smp(16'h8000);
    idle(1);
    chk("burst_last_adc", ADC, 16'h8000);
    chk("burst_pushes", pushes - snap, 3);
    idle(2);
    rd("burst_drained", A_STATUS);
    // offset saturation
    wr(A_OFFSET, 32'hFFFF); smp(16'h7FFF); idle(1);
    chk("sat_hi", ADC, 16'h7FFF);
    wr(A_OFFSET, 32'h0001); smp(16'h8000); idle(1);
    chk("sat_lo", ADC, 16'h8000);
    wr(A_OFFSET, 32'h0002); smp(16'h0005); idle(1);
    chk("offset_sub", ADC, 16'h0003);
    // pace 4 burst
    wr(A_OFFSET, 0); wr(A_PACE, 4);
    snap = pushes;
    for (int i = 0; i < 5; i++) begin
      smp(16'($urandom));
      rd("pace4_status", A_STATUS);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      rd("pace4_drain", A_STATUS);
    end
    chk("pace4_pushes", pushes - snap, 5);
    // overflow with a very slow pacer
    wr(A_PACE, 32'hFFFF);
    for (int i = 0; i < DEPTH + 3; i++) smp(16'($urandom));
    rd("ovf_status", A_STATUS);
    rd("ovf_drops", A_DROPS);
    addr = A_STATUS; read = 1; #1;
    chk("ovf_level_full", Rdata[AW:0], 16);
    read = 0;
    chk("ovf_out", Overflow, 1);
    adc_in = 16'h1234; adc_valid = 1;
    wr(A_STATUS, 0);
    wr(A_DROPS, 0);
    adc_valid = 0;
    rd("clr_drops", A_DROPS);
    rd("clr_status", A_STATUS);
    wr(A_STATUS, 0);
    chk("ovf_cleared", Overflow, 0);
    // flush with coincident capture, then flush a queued batch
    wr(A_DROPS, 0);
    adc_valid = 1;
    wr(A_CTRL, 3);
    adc_valid = 0;
    rd("flush_status", A_STATUS);
    rd("flush_drops", A_DROPS);
    for (int i = 0; i < 8; i++) smp(16'($urandom));
    rd("queued8", A_STATUS);
    wr(A_CTRL, 3);
    snap = pushes;
    idle(10);
    chk("flush_no_push", pushes - snap, 0);
    rd("flush2_status", A_STATUS);
    rd("flush2_drops", A_DROPS);
    // pace 2 with a continuous stream: full FIFO sees write+pop together
    wr(A_PACE, 2);
    for (int i = 0; i < 40; i++) smp(16'($urandom));
    rd("p2_status", A_STATUS);
    rd("p2_drops", A_DROPS);
    idle(40);
    rd("p2_drained", A_STATUS);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      adc_valid = ($urandom % 4) != 0;
      adc_in = 16'($urandom);
      r = $urandom % 40;
      if (r == 0) wr(A_PACE, $urandom % 4);
      else if (r == 1) wr(A_OFFSET, $urandom);
      else if (r == 2) wr(A_CTRL, {30'd0, ($urandom % 4) == 0, ($urandom % 6) != 0});
      else if (r == 3) wr(A_STATUS, 0);
      else if (r == 4) wr(A_DROPS, 0);
      else if (r == 5) begin
        rd("rnd_status", A_STATUS);
        rd("rnd_drops", A_DROPS);
        tick();
      end else tick();
    end
    adc_valid = 0;
    rd("rnd_end_status", A_STATUS);
    rd("rnd_end_drops", A_DROPS);
    // asynchronous reset in the middle of a burst with overflow set
    wr(A_CTRL, 3); wr(A_PACE, 32'hFFFF);
    for (int i = 0; i < DEPTH + 2; i++) smp(16'($urandom));
    wr(A_CTRL, 3); wr(A_PACE, 2);
    for (int i = 0; i < 10; i++) smp(16'($urandom | 1));
    adc_valid = 1;
    rd("pre_rst_status", A_STATUS);
    chk("pre_rst_ovf", Overflow, 1);
    #1; rst = 0; #1;
    chk("async_push", PushADC, 0);
    chk("async_adc", ADC, 0);
    chk("async_ovf", Overflow, 0);
    addr = A_STATUS; read = 1; #1;
    chk("async_rdata", Rdata, 0);
    read = 0; adc_valid = 0;
    mreset();
    @(posedge clk); #1;
    rst = 1;
    rd("post_rst_pace", A_PACE);
    rd("post_rst_status", A_STATUS);
    rd("post_rst_ctrl", A_CTRL);
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
